// File: rtl/led_fade_driver_pkg.sv
// Shared constants for the LED fade driver: default geometry and prescaler ratios,
// plus a helper that sizes counters safely for divide ratios of 1.
package led_pkg;

  localparam int LED_WIDTH      = 18;
  localparam int LED_LEVEL_BITS = 4;
  localparam int LED_PWM_DIV    = 16;
  localparam int LED_DECAY_DIV  = 500000;

  // A divide-by-1 prescaler still needs a 1-bit counter so the compare stays legal.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// LED bus between the PIO output port (master) and the fade driver (slave).
interface led_fade_driver_if
  import led_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH
);

  logic [WIDTH-1:0] led_in;
  logic             fade_en;
  logic [WIDTH-1:0] led_out;
  logic             busy;

  modport master (
    output led_in,
    output fade_en,
    input  led_out,
    input  busy
  );

  modport slave (
    input  led_in,
    input  fade_en,
    output led_out,
    output busy
  );

endinterface

// File: rtl/led_fade_driver_cell.sv
// One LED channel: brightness register with set/clear/decay priority and the
// registered PWM comparator that drives the pin.
module led_fade_cell
  import led_pkg::*;
#(
  parameter int LEVEL_BITS = LED_LEVEL_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_ledIn,
  input  logic                  i_fadeEn,
  input  logic                  i_decayTick,
  input  logic [LEVEL_BITS-1:0] i_pcnt,
  output logic                  o_ledOut,
  output logic                  o_busy
);

  localparam logic [LEVEL_BITS-1:0] MAX_LEVEL = '1;

  logic [LEVEL_BITS-1:0] r_level;
  logic                  r_ledOut;

  // A request always wins over decay, so re-triggering never loses a step to a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level  <= '0;
      r_ledOut <= 1'b0;
    end else begin
      if (i_ledIn) begin
        r_level <= MAX_LEVEL;
      end else if (!i_fadeEn) begin
        r_level <= '0;
      end else if (i_decayTick && (r_level != '0)) begin
        r_level <= r_level - LEVEL_BITS'(1);
      end
      r_ledOut <= (r_level > i_pcnt);
    end
  end

  assign o_ledOut = r_ledOut;
  assign o_busy   = (r_level != '0) && !i_ledIn;

endmodule

// File: rtl/led_fade_driver.sv
// PWM-dimmed LED driver with afterglow: shared PWM/decay prescalers feed one
// fade cell per LED.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int WIDTH      = LED_WIDTH,
  parameter int LEVEL_BITS = LED_LEVEL_BITS,
  parameter int PWM_DIV    = LED_PWM_DIV,
  parameter int DECAY_DIV  = LED_DECAY_DIV
) (
  input  logic               clk,
  input  logic               reset_n,
  led_fade_driver_if.slave   bus
);

  localparam int MAX    = (1 << LEVEL_BITS) - 1;
  localparam int PDIV_W = cntWidth(PWM_DIV);
  localparam int DDIV_W = cntWidth(DECAY_DIV);

  localparam logic [PDIV_W-1:0]     PDIV_LAST = PDIV_W'(PWM_DIV - 1);
  localparam logic [DDIV_W-1:0]     DDIV_LAST = DDIV_W'(DECAY_DIV - 1);
  localparam logic [LEVEL_BITS-1:0] PCNT_LAST = LEVEL_BITS'(MAX - 1);

  logic [PDIV_W-1:0]     r_pdiv;
  logic [DDIV_W-1:0]     r_ddiv;
  logic [LEVEL_BITS-1:0] r_pcnt;
  logic                  w_pwmTick;
  logic                  w_decayTick;
  logic [WIDTH-1:0]      w_ledOut;
  logic [WIDTH-1:0]      w_busyTerm;

  assign w_pwmTick   = (r_pdiv == PDIV_LAST);
  assign w_decayTick = (r_ddiv == DDIV_LAST);

  // The phase stops at MAX-1 so a level of MAX beats every phase and stays solidly on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pdiv <= '0;
      r_pcnt <= '0;
    end else begin
      r_pdiv <= w_pwmTick ? '0 : r_pdiv + PDIV_W'(1);
      if (w_pwmTick) begin
        r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + LEVEL_BITS'(1);
      end
    end
  end

  // Free-running, so the first decay step after a release can land anywhere in the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ddiv <= '0;
    end else begin
      r_ddiv <= w_decayTick ? '0 : r_ddiv + DDIV_W'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    led_fade_cell #(
      .LEVEL_BITS (LEVEL_BITS)
    ) u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_ledIn     (bus.led_in[g]),
      .i_fadeEn    (bus.fade_en),
      .i_decayTick (w_decayTick),
      .i_pcnt      (r_pcnt),
      .o_ledOut    (w_ledOut[g]),
      .o_busy      (w_busyTerm[g])
    );
  end

  assign bus.led_out = w_ledOut;
  assign bus.busy    = |w_busyTerm;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with fast prescalers (PWM_DIV=2, DECAY_DIV=4).
module tb_led_fade_driver;

  localparam int WIDTH      = 18;
  localparam int LEVEL_BITS = 4;
  localparam int PWM_DIV    = 2;
  localparam int DECAY_DIV  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   totalEdges = 0;
  int   baseEdge = 0;
  int   compared = 0;
  int   mismatched = 0;

  led_fade_driver_if #(.WIDTH(WIDTH)) ledIf ();

  led_fade_driver #(
    .WIDTH      (WIDTH),
    .LEVEL_BITS (LEVEL_BITS),
    .PWM_DIV    (PWM_DIV),
    .DECAY_DIV  (DECAY_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ledIf.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) totalEdges <= totalEdges + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ledIn, input logic fadeEn);
    ledIf.led_in  = ledIn;
    ledIf.fade_en = fadeEn;
  endtask

  // Edges counted from the reset release; returns at the negedge after edge n.
  task automatic waitEdge(input int n);
    while ((totalEdges - baseEdge) < n) @(negedge clk);
  endtask

  task automatic resetDut(input logic [WIDTH-1:0] ledIn, input logic fadeEn);
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus(ledIn, fadeEn);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_led_out", 32'(ledIf.led_out), 32'h0);
      checkOutput("reset_busy", 32'(ledIf.busy), 32'h0);
    end
    reset_n  = 1'b1;
    baseEdge = totalEdges;
  endtask

  // Expected level of LED 0 after edge n when its request falls just before dropEdge
  // (dropEdge is a multiple of 4, so the first decay step lands on dropEdge itself).
  function automatic int fadeLevel(input int n, input int dropEdge);
    int dec;
    if (n < 1) return 0;
    if (n < dropEdge) return 15;
    dec = (n - dropEdge) / 4 + 1;
    return (dec >= 15) ? 0 : 15 - dec;
  endfunction

  function automatic int pwmPhase(input int n);
    return (n / 2) % 15;
  endfunction

  initial begin
    applyStimulus('0, 1'b0);

    // Reset with every LED requested, then 2-edge turn-on after release
    resetDut(18'h3FFFF, 1'b1);
    waitEdge(1);
    checkOutput("reset_edge1_out", 32'(ledIf.led_out), 32'h0);
    waitEdge(2);
    checkOutput("reset_edge2_out", 32'(ledIf.led_out), 32'h3FFFF);
    checkOutput("reset_edge2_busy", 32'(ledIf.busy), 32'h0);

    // Steady on: bit 0 constant from edge 2 onward
    resetDut(18'h00001, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      waitEdge(n);
      checkOutput("steady_out", 32'(ledIf.led_out), (n >= 2) ? 32'h1 : 32'h0);
      checkOutput("steady_busy", 32'(ledIf.busy), 32'h0);
    end

    // Fade: bit 0 dropped before edge 20, level reaches 0 at edge 76
    resetDut(18'h00001, 1'b1);
    for (int n = 1; n <= 90; n++) begin
      waitEdge(n);
      checkOutput("fade_out", 32'(ledIf.led_out),
                  (fadeLevel(n - 1, 20) > pwmPhase(n - 1)) ? 32'h1 : 32'h0);
      checkOutput("fade_busy", 32'(ledIf.busy),
                  (n >= 20 && fadeLevel(n, 20) != 0) ? 32'h1 : 32'h0);
      if (n == 19) applyStimulus(18'h00000, 1'b1);
    end

    // No fade: bit 3 drops with fade_en=0
    resetDut(18'h00009, 1'b0);
    waitEdge(10);
    checkOutput("nofade_before", 32'(ledIf.led_out), 32'h9);
    applyStimulus(18'h00001, 1'b0);
    waitEdge(11);
    checkOutput("nofade_edge1", 32'(ledIf.led_out), 32'h9);
    checkOutput("nofade_busy1", 32'(ledIf.busy), 32'h0);
    for (int n = 12; n <= 20; n++) begin
      waitEdge(n);
      checkOutput("nofade_out", 32'(ledIf.led_out), 32'h1);
      checkOutput("nofade_busy", 32'(ledIf.busy), 32'h0);
    end

    // Re-trigger at level 5 in the decay_tick cycle before edge 60
    resetDut(18'h00001, 1'b1);
    waitEdge(19);
    applyStimulus(18'h00000, 1'b1);
    waitEdge(59);
    checkOutput("retrig_busy_l5", 32'(ledIf.busy), 32'h1);
    applyStimulus(18'h00001, 1'b1);
    waitEdge(60);
    checkOutput("retrig_busy_set", 32'(ledIf.busy), 32'h0);
    applyStimulus(18'h00000, 1'b1);
    waitEdge(61);
    checkOutput("retrig_busy_61", 32'(ledIf.busy), 32'h1);
    waitEdge(70);
    checkOutput("retrig_out_70", 32'(ledIf.led_out),
                (fadeLevel(69, 64) > pwmPhase(69)) ? 32'h1 : 32'h0);
    waitEdge(100);
    checkOutput("retrig_busy_100", 32'(ledIf.busy), 32'h1);
    waitEdge(119);
    checkOutput("retrig_busy_119", 32'(ledIf.busy), 32'h1);
    waitEdge(120);
    checkOutput("retrig_busy_120", 32'(ledIf.busy), 32'h0);

    // Async reset mid-fade at level 9
    resetDut(18'h00001, 1'b1);
    waitEdge(19);
    applyStimulus(18'h00000, 1'b1);
    waitEdge(41);
    checkOutput("areset_pre_out", 32'(ledIf.led_out), 32'h1);
    checkOutput("areset_pre_busy", 32'(ledIf.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_out", 32'(ledIf.led_out), 32'h0);
    checkOutput("areset_busy", 32'(ledIf.busy), 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("areset_hold_out", 32'(ledIf.led_out), 32'h0);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
